// File: rtl/bpu_ghr_idx_if.sv
// Gshare front-end bundle: predict request/response, branch update, and PHT port signals.
// The slave side is the predictor; dbg_state exposes its update FSM for checkers.
interface bpu_ghr_idx_if #(
    parameter int IDX_WIDTH = 11,
    parameter int PC_WIDTH  = 32
);
    logic                 i_pred_vld;
    logic [PC_WIDTH-1:0]  i_pred_pc;
    logic                 o_pred_rdy;
    logic                 o_pred_vld;
    logic                 o_pred_taken;
    logic [IDX_WIDTH-1:0] o_pred_ghr;

    logic                 i_upd_vld;
    logic [PC_WIDTH-1:0]  i_upd_pc;
    logic [IDX_WIDTH-1:0] i_upd_ghr;
    logic                 i_upd_taken;
    logic                 i_upd_mispred;
    logic                 o_upd_rdy;

    logic [IDX_WIDTH-1:0] o_pht_ridx;
    logic [1:0]           i_pht_rd_entry;
    logic                 o_pht_wren;
    logic [IDX_WIDTH-1:0] o_pht_widx;
    logic [1:0]           o_pht_wr_entry;

    logic [1:0]           dbg_state;

    modport master (
        output i_pred_vld, i_pred_pc, i_upd_vld, i_upd_pc, i_upd_ghr, i_upd_taken,
               i_upd_mispred, i_pht_rd_entry,
        input  o_pred_rdy, o_pred_vld, o_pred_taken, o_pred_ghr, o_upd_rdy,
               o_pht_ridx, o_pht_wren, o_pht_widx, o_pht_wr_entry, dbg_state
    );

    modport slave (
        input  i_pred_vld, i_pred_pc, i_upd_vld, i_upd_pc, i_upd_ghr, i_upd_taken,
               i_upd_mispred, i_pht_rd_entry,
        output o_pred_rdy, o_pred_vld, o_pred_taken, o_pred_ghr, o_upd_rdy,
               o_pht_ridx, o_pht_wren, o_pht_widx, o_pht_wr_entry, dbg_state
    );
endinterface

// File: rtl/bpu_ghr_idx_module.sv
// Gshare front end: speculative GHR, PC^GHR hashing, update queue and PHT read-modify-write FSM.
// Optional macro BPU_GHR_WR_BYPASS_EN forwards the counter being written to a colliding prediction.
module bpu_ghr_idx_module #(
    parameter int IDX_WIDTH = 11,
    parameter int PC_WIDTH  = 32,
    parameter int UQ_DEPTH  = 4
) (
    input logic          clk,
    input logic          rst,
    bpu_ghr_idx_if.slave bus
);
    localparam int PW = $clog2(UQ_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    // Handshakes: a predict transfers when i_pred_vld & o_pred_rdy (same cycle, reported as
    // o_pred_vld); an update transfers when i_upd_vld & o_upd_rdy; unaccepted beats are dropped.
    logic [1:0]           state, state_n;
    logic [IDX_WIDTH-1:0] spec_ghr;
    logic [1:0]           cnt_q;
    logic [IDX_WIDTH-1:0] q_idx [UQ_DEPTH];
    logic [UQ_DEPTH-1:0]  q_taken;
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [PW:0]          count, count_n;

    logic                 full, empty, push, pop, steal;
    logic [IDX_WIDTH-1:0] pred_idx, head_idx;
    logic [1:0]           wr_entry;

    function automatic logic [1:0] sat(input logic [1:0] c, input logic taken);
        if (taken) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        else       return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    // The queue holds the hashed index rather than pc/ghr; only the hash is ever consumed.
    assign full     = (count == (PW+1)'(UQ_DEPTH));
    assign empty    = (count == '0);
    assign push     = bus.i_upd_vld && !full;
    assign pop      = (state == ST_WR);
    assign count_n  = count + (PW+1)'(push) - (PW+1)'(pop);
    assign head_idx = q_idx[rd_ptr];
    assign pred_idx = bus.i_pred_pc[IDX_WIDTH+1:2] ^ spec_ghr;
    assign steal    = (state == ST_RD) && (!bus.i_pred_vld || full);
    assign wr_entry = sat(cnt_q, q_taken[rd_ptr]);

    assign bus.o_pht_ridx     = steal ? head_idx : pred_idx;
    assign bus.o_pred_rdy     = !((state == ST_RD) && full);
    assign bus.o_pred_vld     = bus.i_pred_vld && bus.o_pred_rdy;
    assign bus.o_pred_ghr     = spec_ghr;
    assign bus.o_upd_rdy      = !full;
    assign bus.o_pht_wren     = pop;
    assign bus.o_pht_widx     = pop ? head_idx : '0;
    assign bus.o_pht_wr_entry = pop ? wr_entry : 2'd0;
    assign bus.dbg_state      = state;

`ifdef BPU_GHR_WR_BYPASS_EN
    assign bus.o_pred_taken = (pop && (pred_idx == head_idx)) ? wr_entry[1]
                                                               : bus.i_pht_rd_entry[1];
`else
    assign bus.o_pred_taken = bus.i_pht_rd_entry[1];
`endif

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (!empty) state_n = ST_RD;
            ST_RD:   if (steal)  state_n = ST_WR;
            ST_WR:   state_n = (count_n != '0) ? ST_RD : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_ghr <= '0;
            state    <= ST_IDLE;
            cnt_q    <= 2'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (steal) cnt_q <= bus.i_pht_rd_entry;
            // A mispredict recovery wins over the same-cycle speculative shift.
            if (push && bus.i_upd_mispred)
                spec_ghr <= {bus.i_upd_ghr[IDX_WIDTH-2:0], bus.i_upd_taken};
            else if (bus.o_pred_vld)
                spec_ghr <= {spec_ghr[IDX_WIDTH-2:0], bus.o_pred_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[wr_ptr]   <= bus.i_upd_pc[IDX_WIDTH+1:2] ^ bus.i_upd_ghr;
            q_taken[wr_ptr] <= bus.i_upd_taken;
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.i_pred_pc[PC_WIDTH-1:IDX_WIDTH+2], bus.i_pred_pc[1:0],
                              bus.i_upd_pc[PC_WIDTH-1:IDX_WIDTH+2], bus.i_upd_pc[1:0]};
endmodule
